// File: rtl/xtimer.sv
// xtimer: memory-mapped down-counting timer with prescaler, one-shot/auto-reload modes and irq
//   clk, rst_n     : clock and asynchronous active-low reset
//   sel, we, addr  : decoder select, write enable, register offset (0 CTRL, 1 LOAD, 2 COUNT, 3 STATUS)
//   data_in        : write data
//   data_to_rd     : combinational read data, zero while not selected
//   irq            : EXPIRED & IRQ_EN
module xtimer #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 2,
    parameter int PRESC_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sel,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0]     data_in,
    output logic [DATA_W-1:0]     data_to_rd,
    output logic                  irq
);
    localparam logic [REG_ADDR_W-1:0] A_CTRL   = REG_ADDR_W'(0);
    localparam logic [REG_ADDR_W-1:0] A_LOAD   = REG_ADDR_W'(1);
    localparam logic [REG_ADDR_W-1:0] A_COUNT  = REG_ADDR_W'(2);
    localparam logic [REG_ADDR_W-1:0] A_STATUS = REG_ADDR_W'(3);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state, state_next;
    logic                 en, auto_reload, irq_en, expired;
    logic                 en_next, expired_next;
    logic [PRESC_W-1:0]   presc, pcnt, pcnt_next;
    logic [DATA_W-1:0]    load, count, count_next, ctrl_rd;
    logic                 wr, wr_ctrl, wr_load, wr_count, wr_status, stop_wr, tick, expire;

    assign wr        = sel && we;
    assign wr_ctrl   = wr && addr == A_CTRL;
    assign wr_load   = wr && addr == A_LOAD;
    assign wr_count  = wr && addr == A_COUNT;
    assign wr_status = wr && addr == A_STATUS;
    // a write clearing EN freezes COUNT on that very edge
    assign stop_wr   = wr_ctrl && !data_in[0];
    assign tick      = state == RUN && pcnt == presc && !stop_wr;
    // a COUNT write on a tick edge overrides both decrement and expiry
    assign expire    = tick && !wr_count && count <= DATA_W'(1);

    always_comb begin
        en_next      = wr_ctrl ? data_in[0] : (expire && !auto_reload) ? 1'b0 : en;
        state_next   = en_next ? RUN : IDLE;
        pcnt_next    = (state_next == IDLE || state == IDLE || tick || wr_count) ? '0 : pcnt + 1'b1;
        count_next   = wr_count ? data_in :
                       !tick    ? count :
                       expire   ? (auto_reload ? load : '0) : count - DATA_W'(1);
        // a new expiry beats a simultaneous clear-write
        expired_next = expire ? 1'b1 : (wr_status && data_in[0]) ? 1'b0 : expired;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            en          <= 1'b0;
            auto_reload <= 1'b0;
            irq_en      <= 1'b0;
            presc       <= '0;
            load        <= '0;
            count       <= '0;
            pcnt        <= '0;
            expired     <= 1'b0;
        end else begin
            state   <= state_next;
            en      <= en_next;
            pcnt    <= pcnt_next;
            count   <= count_next;
            expired <= expired_next;
            if (wr_ctrl) begin
                auto_reload <= data_in[1];
                irq_en      <= data_in[2];
                presc       <= data_in[DATA_W-1 -: PRESC_W];
            end
            if (wr_load) load <= data_in;
        end
    end

    assign ctrl_rd = {presc, {(DATA_W-PRESC_W-3){1'b0}}, irq_en, auto_reload, en};

    always_comb begin
        data_to_rd = !sel               ? '0 :
                     addr == A_CTRL     ? ctrl_rd :
                     addr == A_LOAD     ? load :
                     addr == A_COUNT    ? count :
                     addr == A_STATUS   ? DATA_W'(expired) : '0;
    end

    assign irq = expired && irq_en;
endmodule

// File: tb/tb_xtimer.sv
// tb_xtimer: directed scoreboard bench for xtimer
module tb_xtimer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  addr = '0;
    logic [31:0] data_in = '0;
    logic [31:0] data_to_rd;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    xtimer dut (
        .clk(clk), .rst_n(rst_n), .sel(sel), .we(we), .addr(addr),
        .data_in(data_in), .data_to_rd(data_to_rd), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic cmp(input logic [31:0] obs);
        logic [31:0] e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_cmp++;
        assert (obs === e) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", t, obs, e);
        end
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string t, input logic s = 1'b1);
        exp_q.push_back(e);
        tag_q.push_back(t);
        sel = s; we = 1'b0; addr = a;
        #1;
        cmp(data_to_rd);
        sel = 1'b0;
    endtask

    task automatic chk_irq(input logic e, input string t);
        exp_q.push_back({31'b0, e});
        tag_q.push_back(t);
        cmp({31'b0, irq});
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; we = 1'b1; addr = a; data_in = d;
        @(posedge clk);
        #1;
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
        rd(0, 0, "rst_ctrl");
        rd(1, 0, "rst_load");
        rd(2, 0, "rst_count");
        rd(3, 0, "rst_status");
        chk_irq(0, "rst_irq");

        // one-shot, PRESC=0
        wr(1, 5); wr(2, 5); wr(0, 32'h0000_0005);
        for (int i = 4; i >= 1; i--) begin
            idle(1);
            rd(2, i, $sformatf("os_count%0d", i));
            if (i == 4) rd(2, 0, "nosel_zero", 1'b0);
        end
        rd(3, 0, "os_not_yet");
        idle(1);
        rd(3, 1, "os_expired");
        chk_irq(1, "os_irq");
        rd(2, 0, "os_count0");
        rd(0, 32'h4, "os_en_cleared");
        wr(3, 0);
        rd(3, 1, "status_wr0_noop");
        wr(3, 1);
        chk_irq(0, "os_irq_cleared");
        rd(3, 0, "os_status_cleared");

        // auto-reload, PRESC=2
        wr(1, 3); wr(2, 3); wr(0, 32'h0002_0003);
        idle(8);
        rd(3, 0, "ar_not_yet");
        rd(2, 1, "ar_count1");
        idle(1);
        rd(3, 1, "ar_expired");
        rd(2, 3, "ar_reloaded");
        chk_irq(0, "ar_irq_masked");
        wr(3, 1);
        rd(3, 0, "ar_cleared");
        idle(7);
        rd(3, 0, "ar_not_yet2");
        idle(1);
        rd(3, 1, "ar_expired2");

        // clear-write on the expiry edge: set wins
        wr(3, 1);
        rd(3, 0, "col_pre_clear");
        idle(7);
        wr(3, 1);
        rd(3, 1, "col_set_wins");
        rd(2, 3, "col_reload");

        // COUNT write on a tick edge
        idle(2);
        wr(2, 100);
        rd(2, 100, "col_count_wr");
        idle(2);
        rd(2, 100, "col_presc_reset");
        idle(1);
        rd(2, 99, "col_decrement");
        wr(0, 0);
        rd(0, 0, "ctrl_off");

        // pause and resume, PRESC=1
        wr(2, 10); wr(0, 32'h0001_0001);
        idle(8);
        rd(2, 6, "pause_4ticks");
        wr(0, 32'h0001_0000);
        rd(2, 6, "pause_hold_edge");
        idle(5);
        rd(2, 6, "pause_frozen");
        wr(0, 32'h0001_0001);
        idle(1);
        rd(2, 6, "resume_wait");
        idle(1);
        rd(2, 5, "resume_dec");

        // asynchronous reset mid-count with irq high
        wr(0, 0);
        wr(3, 1);
        wr(1, 2); wr(2, 2); wr(0, 32'h0000_0007);
        idle(2);
        chk_irq(1, "pre_rst_irq");
        rd(2, 2, "pre_rst_count");
        #1 rst_n = 1'b0;
        #1 chk_irq(0, "async_rst_irq");
        rd(2, 0, "async_rst_count");
        rd(0, 0, "async_rst_ctrl");
        rd(1, 0, "async_rst_load");
        rd(3, 0, "async_rst_status");
        idle(1);
        rst_n = 1'b1;
        idle(3);
        rd(2, 0, "post_rst_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
